// File: rtl/loom_axil_arbiter.sv
// Round-robin N:1 AXI-Lite arbiter with independent read and write grants.
// A grant is held from address acceptance until its response handshake completes.
module loom_axil_arbiter #(
  parameter  int ADDR_WIDTH = 20,
  parameter  int N_REQ      = 3,
  localparam int IDX_W      = $clog2(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // requester-side read channels
  input  logic [N_REQ*ADDR_WIDTH-1:0] s_axil_araddr_i,
  input  logic [N_REQ-1:0]            s_axil_arvalid_i,
  output logic [N_REQ-1:0]            s_axil_arready_o,
  output logic [N_REQ*32-1:0]         s_axil_rdata_o,
  output logic [N_REQ*2-1:0]          s_axil_rresp_o,
  output logic [N_REQ-1:0]            s_axil_rvalid_o,
  input  logic [N_REQ-1:0]            s_axil_rready_i,
  // requester-side write channels
  input  logic [N_REQ*ADDR_WIDTH-1:0] s_axil_awaddr_i,
  input  logic [N_REQ-1:0]            s_axil_awvalid_i,
  output logic [N_REQ-1:0]            s_axil_awready_o,
  input  logic [N_REQ*32-1:0]         s_axil_wdata_i,
  input  logic [N_REQ*4-1:0]          s_axil_wstrb_i,
  input  logic [N_REQ-1:0]            s_axil_wvalid_i,
  output logic [N_REQ-1:0]            s_axil_wready_o,
  output logic [N_REQ*2-1:0]          s_axil_bresp_o,
  output logic [N_REQ-1:0]            s_axil_bvalid_o,
  input  logic [N_REQ-1:0]            s_axil_bready_i,
  // shared master port
  output logic [ADDR_WIDTH-1:0]       m_axil_araddr_o,
  output logic                        m_axil_arvalid_o,
  input  logic                        m_axil_arready_i,
  input  logic [31:0]                 m_axil_rdata_i,
  input  logic [1:0]                  m_axil_rresp_i,
  input  logic                        m_axil_rvalid_i,
  output logic                        m_axil_rready_o,
  output logic [ADDR_WIDTH-1:0]       m_axil_awaddr_o,
  output logic                        m_axil_awvalid_o,
  input  logic                        m_axil_awready_i,
  output logic [31:0]                 m_axil_wdata_o,
  output logic [3:0]                  m_axil_wstrb_o,
  output logic                        m_axil_wvalid_o,
  input  logic                        m_axil_wready_i,
  input  logic [1:0]                  m_axil_bresp_i,
  input  logic                        m_axil_bvalid_i,
  output logic                        m_axil_bready_o,
  // debug
  output logic [IDX_W-1:0]            rd_grant_o,
  output logic [IDX_W-1:0]            wr_grant_o
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  rd_state_e        rd_state_q;
  wr_state_e        wr_state_q;
  logic [IDX_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [IDX_W-1:0] rd_grant_q, wr_grant_q;
  logic             aw_done_q, w_done_q;

  logic [ADDR_WIDTH-1:0] ar_addr [N_REQ];
  logic [ADDR_WIDTH-1:0] aw_addr [N_REQ];
  logic [31:0]           w_data  [N_REQ];
  logic [3:0]            w_strb  [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign ar_addr[i] = s_axil_araddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign aw_addr[i] = s_axil_awaddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data[i]  = s_axil_wdata_i[i*32 +: 32];
    assign w_strb[i]  = s_axil_wstrb_i[i*4 +: 4];
  end

  // First requesting index at or above ptr, wrapping past N_REQ-1 back to 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  logic ar_fire, r_fire, aw_fire, w_fire, b_fire;
  assign ar_fire = m_axil_arvalid_o && m_axil_arready_i;
  assign r_fire  = m_axil_rvalid_i  && m_axil_rready_o;
  assign aw_fire = m_axil_awvalid_o && m_axil_awready_i;
  assign w_fire  = m_axil_wvalid_o  && m_axil_wready_i;
  assign b_fire  = m_axil_bvalid_i  && m_axil_bready_o;

  // Data and address paths are free-running muxes; only valids and readies are gated.
  assign m_axil_araddr_o = ar_addr[rd_grant_q];
  assign m_axil_awaddr_o = aw_addr[wr_grant_q];
  assign m_axil_wdata_o  = w_data[wr_grant_q];
  assign m_axil_wstrb_o  = w_strb[wr_grant_q];
  assign s_axil_rdata_o  = {N_REQ{m_axil_rdata_i}};
  assign s_axil_rresp_o  = {N_REQ{m_axil_rresp_i}};
  assign s_axil_bresp_o  = {N_REQ{m_axil_bresp_i}};
  assign rd_grant_o      = rd_grant_q;
  assign wr_grant_o      = wr_grant_q;

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise the unassigned paths turn into latches.
  always_comb begin
    s_axil_arready_o = '0;
    s_axil_rvalid_o  = '0;
    m_axil_arvalid_o = 1'b0;
    m_axil_rready_o  = 1'b0;
    case (rd_state_q)
      R_ADDR: begin
        m_axil_arvalid_o             = s_axil_arvalid_i[rd_grant_q];
        s_axil_arready_o[rd_grant_q] = m_axil_arready_i;
      end
      R_RESP: begin
        s_axil_rvalid_o[rd_grant_q] = m_axil_rvalid_i;
        m_axil_rready_o             = s_axil_rready_i[rd_grant_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    s_axil_awready_o = '0;
    s_axil_wready_o  = '0;
    s_axil_bvalid_o  = '0;
    m_axil_awvalid_o = 1'b0;
    m_axil_wvalid_o  = 1'b0;
    m_axil_bready_o  = 1'b0;
    case (wr_state_q)
      W_DATA: begin
        m_axil_awvalid_o             = !aw_done_q && s_axil_awvalid_i[wr_grant_q];
        s_axil_awready_o[wr_grant_q] = !aw_done_q && m_axil_awready_i;
        m_axil_wvalid_o              = !w_done_q && s_axil_wvalid_i[wr_grant_q];
        s_axil_wready_o[wr_grant_q]  = !w_done_q && m_axil_wready_i;
      end
      W_RESP: begin
        s_axil_bvalid_o[wr_grant_q] = m_axil_bvalid_i;
        m_axil_bready_o             = s_axil_bready_i[wr_grant_q];
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= R_IDLE;
      rd_ptr_q   <= '0;
      rd_grant_q <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (|s_axil_arvalid_i) begin
          rd_grant_q <= rr_pick(s_axil_arvalid_i, rd_ptr_q);
          rd_state_q <= R_ADDR;
        end
        R_ADDR: if (ar_fire) rd_state_q <= R_RESP;
        R_RESP: if (r_fire) begin
          rd_ptr_q   <= next_idx(rd_grant_q);
          rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= W_IDLE;
      wr_ptr_q   <= '0;
      wr_grant_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (|s_axil_awvalid_i) begin
          wr_grant_q <= rr_pick(s_axil_awvalid_i, wr_ptr_q);
          wr_state_q <= W_DATA;
        end
        W_DATA: begin
          if (aw_fire) aw_done_q <= 1'b1;
          if (w_fire)  w_done_q  <= 1'b1;
          if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) wr_state_q <= W_RESP;
        end
        W_RESP: if (b_fire) begin
          aw_done_q  <= 1'b0;
          w_done_q   <= 1'b0;
          wr_ptr_q   <= next_idx(wr_grant_q);
          wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loom_axil_arbiter.sv
// Directed bench for loom_axil_arbiter: a table of read transactions with
// hand-computed round-robin grants plus hand-written multi-cycle sequences.
module tb_loom_axil_arbiter;

  localparam int AW = 20;
  localparam int N  = 3;

  logic            clk_i, rst_ni;
  logic [N*AW-1:0] s_axil_araddr_i, s_axil_awaddr_i;
  logic [N-1:0]    s_axil_arvalid_i, s_axil_arready_o, s_axil_rvalid_o, s_axil_rready_i;
  logic [N*32-1:0] s_axil_rdata_o, s_axil_wdata_i;
  logic [N*2-1:0]  s_axil_rresp_o, s_axil_bresp_o;
  logic [N-1:0]    s_axil_awvalid_i, s_axil_awready_o, s_axil_wvalid_i, s_axil_wready_o;
  logic [N*4-1:0]  s_axil_wstrb_i;
  logic [N-1:0]    s_axil_bvalid_o, s_axil_bready_i;
  logic [AW-1:0]   m_axil_araddr_o, m_axil_awaddr_o;
  logic            m_axil_arvalid_o, m_axil_arready_i, m_axil_rvalid_i, m_axil_rready_o;
  logic [31:0]     m_axil_rdata_i, m_axil_wdata_o;
  logic [1:0]      m_axil_rresp_i, m_axil_bresp_i;
  logic            m_axil_awvalid_o, m_axil_awready_i, m_axil_wvalid_o, m_axil_wready_i;
  logic [3:0]      m_axil_wstrb_o;
  logic            m_axil_bvalid_i, m_axil_bready_o;
  logic [1:0]      rd_grant_o, wr_grant_o;

  loom_axil_arbiter #(.ADDR_WIDTH(AW), .N_REQ(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_axil_araddr_i(s_axil_araddr_i), .s_axil_arvalid_i(s_axil_arvalid_i),
    .s_axil_arready_o(s_axil_arready_o), .s_axil_rdata_o(s_axil_rdata_o),
    .s_axil_rresp_o(s_axil_rresp_o), .s_axil_rvalid_o(s_axil_rvalid_o),
    .s_axil_rready_i(s_axil_rready_i), .s_axil_awaddr_i(s_axil_awaddr_i),
    .s_axil_awvalid_i(s_axil_awvalid_i), .s_axil_awready_o(s_axil_awready_o),
    .s_axil_wdata_i(s_axil_wdata_i), .s_axil_wstrb_i(s_axil_wstrb_i),
    .s_axil_wvalid_i(s_axil_wvalid_i), .s_axil_wready_o(s_axil_wready_o),
    .s_axil_bresp_o(s_axil_bresp_o), .s_axil_bvalid_o(s_axil_bvalid_o),
    .s_axil_bready_i(s_axil_bready_i),
    .m_axil_araddr_o(m_axil_araddr_o), .m_axil_arvalid_o(m_axil_arvalid_o),
    .m_axil_arready_i(m_axil_arready_i), .m_axil_rdata_i(m_axil_rdata_i),
    .m_axil_rresp_i(m_axil_rresp_i), .m_axil_rvalid_i(m_axil_rvalid_i),
    .m_axil_rready_o(m_axil_rready_o), .m_axil_awaddr_o(m_axil_awaddr_o),
    .m_axil_awvalid_o(m_axil_awvalid_o), .m_axil_awready_i(m_axil_awready_i),
    .m_axil_wdata_o(m_axil_wdata_o), .m_axil_wstrb_o(m_axil_wstrb_o),
    .m_axil_wvalid_o(m_axil_wvalid_o), .m_axil_wready_i(m_axil_wready_i),
    .m_axil_bresp_i(m_axil_bresp_i), .m_axil_bvalid_i(m_axil_bvalid_i),
    .m_axil_bready_o(m_axil_bready_o),
    .rd_grant_o(rd_grant_o), .wr_grant_o(wr_grant_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " s_ready"}, {s_axil_arready_o, s_axil_awready_o, s_axil_wready_o}, '0);
    check({tag, " s_valid"}, {s_axil_rvalid_o, s_axil_bvalid_o}, '0);
    check({tag, " m_valid"}, {m_axil_arvalid_o, m_axil_awvalid_o, m_axil_wvalid_o}, '0);
    check({tag, " m_ready"}, {m_axil_rready_o, m_axil_bready_o}, '0);
    check({tag, " grants"},  {rd_grant_o, wr_grant_o}, '0);
  endtask

  task automatic drive_idle();
    s_axil_araddr_i  = '0; s_axil_arvalid_i = '0; s_axil_rready_i = '0;
    s_axil_awaddr_i  = '0; s_axil_awvalid_i = '0; s_axil_wdata_i  = '0;
    s_axil_wstrb_i   = '0; s_axil_wvalid_i  = '0; s_axil_bready_i = '0;
    m_axil_arready_i = 1'b0; m_axil_rdata_i = '0; m_axil_rresp_i = '0;
    m_axil_rvalid_i  = 1'b0; m_axil_awready_i = 1'b0; m_axil_wready_i = 1'b0;
    m_axil_bresp_i   = '0; m_axil_bvalid_i = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]         req;
    logic [N-1:0][AW-1:0] addr;
    logic [31:0]          data;
    logic [1:0]           resp;
    int                   grant;
  } rd_vec_t;

  rd_vec_t vecs [7];

  function automatic rd_vec_t mk(input logic [N-1:0] req, input logic [AW-1:0] a2,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                                 input logic [31:0] data, input logic [1:0] resp,
                                 input int grant);
    rd_vec_t v;
    v.req = req; v.addr = {a2, a1, a0}; v.data = data; v.resp = resp; v.grant = grant;
    return v;
  endfunction

  int          exp_seq [6] = '{0, 1, 2, 0, 1, 2};
  int          n;
  logic [N-1:0] oh;

  initial begin
    // Pointer walks 0 -> 2 -> 1 -> 0 -> 2 -> 0 -> 0 -> 1 through this table.
    vecs[0] = mk(3'b010, 20'h0, 20'h00104, 20'h0, 32'hCAFE0001, 2'b00, 1);
    vecs[1] = mk(3'b011, 20'h0, 20'h01110, 20'h01000, 32'h11111111, 2'b10, 0);
    vecs[2] = mk(3'b101, 20'h22220, 20'h0, 20'h02000, 32'h22222222, 2'b00, 2);
    vecs[3] = mk(3'b110, 20'h33330, 20'h31110, 20'h0, 32'h33333333, 2'b11, 1);
    vecs[4] = mk(3'b111, 20'h42220, 20'h41110, 20'h40000, 32'h44444444, 2'b01, 2);
    vecs[5] = mk(3'b100, 20'hF5550, 20'h0, 20'h0, 32'h55555555, 2'b00, 2);
    vecs[6] = mk(3'b001, 20'h0, 20'h0, 20'h6000C, 32'h66666666, 2'b10, 0);

    drive_idle();
    rst_ni = 1'b0;
    #3;
    check_quiet("reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Contention: all three keep arvalid high; slave always ready.
    @(negedge clk_i);
    s_axil_arvalid_i = 3'b111; m_axil_arready_i = 1'b1;
    m_axil_rvalid_i = 1'b1; s_axil_rready_i = 3'b111;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk_i);
      if (m_axil_arvalid_o) begin
        check($sformatf("contention grant %0d", n), 64'(rd_grant_o), 64'(exp_seq[n]));
        n++;
      end
    end
    check("contention grant count", 64'(n), 64'd6);
    s_axil_arvalid_i = 3'b100;
    @(negedge clk_i);
    s_axil_arvalid_i = '0;
    check("contention last rvalid", 64'(s_axil_rvalid_o), 64'b100);
    @(negedge clk_i);
    drive_idle();

    // Table-driven read transactions.
    for (int k = 0; k < 7; k++) begin
      oh = 3'b001 << vecs[k].grant;
      @(negedge clk_i);
      s_axil_arvalid_i = vecs[k].req;
      s_axil_araddr_i  = vecs[k].addr;
      #1;
      check($sformatf("v%0d bubble arvalid", k), 64'(m_axil_arvalid_o), 64'd0);
      @(negedge clk_i);
      check($sformatf("v%0d rd_grant", k), 64'(rd_grant_o), 64'(vecs[k].grant));
      check($sformatf("v%0d m_arvalid", k), 64'(m_axil_arvalid_o), 64'd1);
      check($sformatf("v%0d m_araddr", k), 64'(m_axil_araddr_o), 64'(vecs[k].addr[vecs[k].grant]));
      m_axil_arready_i = 1'b1;
      #1;
      check($sformatf("v%0d s_arready", k), 64'(s_axil_arready_o), 64'(oh));
      @(negedge clk_i);
      s_axil_arvalid_i = vecs[k].req & ~oh;
      m_axil_arready_i = 1'b0;
      m_axil_rvalid_i = 1'b1; m_axil_rdata_i = vecs[k].data; m_axil_rresp_i = vecs[k].resp;
      s_axil_rready_i = 3'b111;
      #1;
      check($sformatf("v%0d resp m_arvalid", k), 64'(m_axil_arvalid_o), 64'd0);
      check($sformatf("v%0d s_rvalid", k), 64'(s_axil_rvalid_o), 64'(oh));
      check($sformatf("v%0d rdata", k), 64'(s_axil_rdata_o[vecs[k].grant*32 +: 32]), 64'(vecs[k].data));
      check($sformatf("v%0d rresp", k), 64'(s_axil_rresp_o[vecs[k].grant*2 +: 2]), 64'(vecs[k].resp));
      check($sformatf("v%0d m_rready", k), 64'(m_axil_rready_o), 64'd1);
      @(negedge clk_i);
      drive_idle();
      #1;
      check($sformatf("v%0d grant held", k), 64'(rd_grant_o), 64'(vecs[k].grant));
      check($sformatf("v%0d idle rvalid", k), 64'(s_axil_rvalid_o), 64'd0);
    end

    // Write ordering: requester 2 presents W two cycles ahead of AW.
    @(negedge clk_i);
    s_axil_wvalid_i = 3'b100; s_axil_wdata_i[64 +: 32] = 32'h12345678;
    s_axil_wstrb_i[8 +: 4] = 4'hF; m_axil_awready_i = 1'b1; m_axil_wready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check("w-only master valids", {m_axil_awvalid_o, m_axil_wvalid_o}, '0);
      check("w-only s_wready", 64'(s_axil_wready_o), 64'd0);
    end
    s_axil_awvalid_i = 3'b100; s_axil_awaddr_i[40 +: AW] = 20'h00200;
    @(negedge clk_i);
    check("wo wr_grant", 64'(wr_grant_o), 64'd2);
    check("wo master valids", {m_axil_awvalid_o, m_axil_wvalid_o}, 2'b11);
    check("wo awaddr", 64'(m_axil_awaddr_o), 64'h00200);
    check("wo wdata/wstrb", {m_axil_wdata_o, m_axil_wstrb_o}, {32'h12345678, 4'hF});
    check("wo s readies", {s_axil_awready_o, s_axil_wready_o}, {3'b100, 3'b100});
    @(negedge clk_i);
    check("wo resp master valids", {m_axil_awvalid_o, m_axil_wvalid_o}, '0);
    s_axil_awvalid_i = '0; s_axil_wvalid_i = '0;
    m_axil_bvalid_i = 1'b1; m_axil_bresp_i = 2'b10; s_axil_bready_i = 3'b111;
    #1;
    check("wo s_bvalid", 64'(s_axil_bvalid_o), 64'b100);
    check("wo bresp", 64'(s_axil_bresp_o[4 +: 2]), 64'b10);
    check("wo m_bready", 64'(m_axil_bready_o), 64'd1);
    @(negedge clk_i);
    drive_idle();
    #1;
    check("wo done bvalid", 64'(s_axil_bvalid_o), 64'd0);

    // Concurrency: requester 0 reads while requester 1 writes; W lags AW.
    @(negedge clk_i);
    s_axil_arvalid_i = 3'b001; s_axil_araddr_i[0 +: AW] = 20'h00300;
    s_axil_awvalid_i = 3'b010; s_axil_awaddr_i[20 +: AW] = 20'h00400;
    s_axil_wvalid_i = 3'b010; s_axil_wdata_i[32 +: 32] = 32'hDEADBEEF; s_axil_wstrb_i[4 +: 4] = 4'h3;
    m_axil_arready_i = 1'b1; m_axil_awready_i = 1'b1;
    @(negedge clk_i);
    check("cc grants", {rd_grant_o, wr_grant_o}, {2'd0, 2'd1});
    check("cc master valids", {m_axil_arvalid_o, m_axil_awvalid_o, m_axil_wvalid_o}, 3'b111);
    check("cc s_wready stalled", 64'(s_axil_wready_o), 64'd0);
    @(negedge clk_i);
    s_axil_arvalid_i = '0;
    check("cc aw suppressed", {m_axil_awvalid_o, s_axil_awready_o}, '0);
    check("cc w still valid", 64'(m_axil_wvalid_o), 64'd1);
    m_axil_wready_i = 1'b1; m_axil_rvalid_i = 1'b1; m_axil_rdata_i = 32'h55AA55AA;
    s_axil_rready_i = 3'b001;
    #1;
    check("cc s_rvalid", 64'(s_axil_rvalid_o), 64'b001);
    check("cc rdata", 64'(s_axil_rdata_o[0 +: 32]), 64'h55AA55AA);
    check("cc s_wready", 64'(s_axil_wready_o), 64'b010);
    @(negedge clk_i);
    s_axil_awvalid_i = '0; s_axil_wvalid_i = '0; m_axil_rvalid_i = 1'b0; m_axil_wready_i = 1'b0;
    m_axil_bvalid_i = 1'b1; m_axil_bresp_i = 2'b00; s_axil_bready_i = 3'b010;
    #1;
    check("cc s_bvalid", 64'(s_axil_bvalid_o), 64'b010);
    check("cc resp master valids", {m_axil_awvalid_o, m_axil_wvalid_o}, '0);
    @(negedge clk_i);
    drive_idle();
    #1;
    check("cc done bvalid", 64'(s_axil_bvalid_o), 64'd0);

    // Backpressure: requester 0 stalls rready while requester 1 waits.
    @(negedge clk_i);
    s_axil_arvalid_i = 3'b001; m_axil_arready_i = 1'b1;
    @(negedge clk_i);
    check("bp first grant", 64'(rd_grant_o), 64'd0);
    @(negedge clk_i);
    s_axil_arvalid_i = 3'b010; m_axil_rvalid_i = 1'b1; s_axil_rready_i = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check("bp m_rready", 64'(m_axil_rready_o), 64'd0);
      check("bp grant held", 64'(rd_grant_o), 64'd0);
      check("bp r1 blocked", {m_axil_arvalid_o, s_axil_arready_o}, '0);
    end
    s_axil_rready_i = 3'b001;
    #1;
    check("bp m_rready released", 64'(m_axil_rready_o), 64'd1);
    @(negedge clk_i);
    m_axil_rvalid_i = 1'b0; s_axil_rready_i = '0;
    check("bp idle bubble", 64'(m_axil_arvalid_o), 64'd0);
    @(negedge clk_i);
    check("bp second grant", 64'(rd_grant_o), 64'd1);
    check("bp second arvalid", 64'(m_axil_arvalid_o), 64'd1);
    m_axil_awready_i = 1'b0; s_axil_awvalid_i = 3'b100;

    // Reset while the read sits in R_RESP and the write in W_DATA.
    @(negedge clk_i);
    s_axil_arvalid_i = '0; m_axil_rvalid_i = 1'b1; s_axil_rready_i = 3'b010;
    #1;
    check("pre-reset s_rvalid", 64'(s_axil_rvalid_o), 64'b010);
    check("pre-reset wr_grant", 64'(wr_grant_o), 64'd2);
    rst_ni = 1'b0;
    #1;
    check_quiet("mid reset");
    drive_idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    s_axil_arvalid_i = 3'b100; m_axil_arready_i = 1'b1;
    @(negedge clk_i);
    check("post-reset grant", 64'(rd_grant_o), 64'd2);
    check("post-reset arvalid", 64'(m_axil_arvalid_o), 64'd1);
    check("post-reset s_arready", 64'(s_axil_arready_o), 64'b100);
    @(negedge clk_i);
    s_axil_arvalid_i = '0; m_axil_arready_i = 1'b0; m_axil_rvalid_i = 1'b1; s_axil_rready_i = 3'b100;
    #1;
    check("post-reset s_rvalid", 64'(s_axil_rvalid_o), 64'b100);
    @(negedge clk_i);
    drive_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
